// File: rtl/data_mem_responder.sv
// Word-addressed 16-bit data memory behind a req/ack handshake, with a
// programmable number of wait states and an out-of-range error response.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [13:0] idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ok_q, ok_d;
  logic        mem_we;
  logic [1:0]  unused_byte_offset;

  logic [15:0] mem_q [DEPTH];

  assign unused_byte_offset = addr[1:0];

  // Range test uses the full 14-bit index so e.g. index 1024 never aliases word 0.
  assign ok_q = ({18'd0, idx_q} < 32'(DEPTH));
  assign ok_d = ({18'd0, idx_d} < 32'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        we_d    = we;
        idx_d   = addr[15:2];
        wdata_d = wdata;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        mem_we  = we_q && ok_q;
        state_d = S_HOLD;
      end
      S_HOLD: if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Load data is fetched on the edge entering RESP so it lines up with ack.
    if (state_d == S_RESP && state_q != S_RESP && !we_d)
      rdata_d = ok_d ? mem_q[idx_d[AW-1:0]] : 16'h0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= 14'd0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; an aborted RESP drops mem_we immediately.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx_q[AW-1:0]] <= wdata_q;
  end

  assign ack   = (state_q == S_RESP);
  assign err   = ack && !ok_q;
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: two responders (2 wait states, 0 wait states) checked each
// cycle against a transaction-timeline model, plus literal expectations.
module tb_data_mem_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [15:0] addr_s  [2];
  logic [15:0] wdata_s [2];
  logic        ack_s   [2];
  logic [15:0] rdata_s [2];
  logic        err_s   [2];
  logic        busy_s  [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset), .req(req_s[0]), .we(we_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ack(ack_s[0]),
    .rdata(rdata_s[0]), .err(err_s[0]), .busy(busy_s[0]));

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset), .req(req_s[1]), .we(we_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ack(ack_s[1]),
    .rdata(rdata_s[1]), .err(err_s[1]), .busy(busy_s[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Timeline model: phase 0 idle, 1 transaction pending, 2 waiting for req to drop.
  int          cyc = 0;
  int          ph      [2];
  int          resp_at [2];
  logic [13:0] c_idx   [2];
  logic        c_we    [2];
  logic [15:0] c_wd    [2];
  logic [15:0] m_rd    [2];
  logic [15:0] mm      [2][1024];

  initial for (int k = 0; k < 2; k++) begin ph[k] = 0; m_rd[k] = 16'h0; resp_at[k] = -10; end

  task automatic resp_entry(input int k);
    if (!c_we[k]) m_rd[k] = (c_idx[k] < 14'd1024) ? mm[k][c_idx[k][9:0]] : 16'h0000;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin ph[k] = 0; m_rd[k] = 16'h0; end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        case (ph[k])
          0: if (req_s[k]) begin
            c_idx[k]   = addr_s[k][15:2];
            c_we[k]    = we_s[k];
            c_wd[k]    = wdata_s[k];
            resp_at[k] = cyc + ((k == 0) ? 2 : 0);
            ph[k]      = 1;
            if (resp_at[k] == cyc) resp_entry(k);
          end
          1: if (cyc == resp_at[k]) resp_entry(k);
             else if (cyc == resp_at[k] + 1) begin
               if (c_we[k] && c_idx[k] < 14'd1024) mm[k][c_idx[k][9:0]] = c_wd[k];
               ph[k] = 2;
             end
          default: if (!req_s[k]) ph[k] = 0;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      logic ea;
      ea = (ph[k] == 1) && (cyc == resp_at[k]);
      chk($sformatf("dut%0d_ack", k), ack_s[k], ea);
      chk($sformatf("dut%0d_busy", k), busy_s[k], ph[k] != 0);
      chk($sformatf("dut%0d_rdata", k), rdata_s[k], m_rd[k]);
      if (ea) chk($sformatf("dut%0d_err", k), err_s[k], c_idx[k] >= 14'd1024);
    end
  end

  // Called at a negedge; returns ack-time results and the number of acks seen.
  task automatic xact(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input int hold, output logic [15:0] rd, output logic e,
                      output int lat, output int nack, output logic b);
    req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    lat = 0; nack = 0; rd = 16'h0; e = 1'b0; b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      lat++;
      if (ack_s[k]) begin nack = 1; rd = rdata_s[k]; e = err_s[k]; b = busy_s[k]; break; end
    end
    if (nack == 0) chk($sformatf("dut%0d_ack_timeout", k), nack, 1);
    repeat (hold) begin @(negedge clock); if (ack_s[k]) nack++; end
    req_s[k] = 1'b0;
    repeat ((hold > 0) ? 1 : 2) begin @(negedge clock); if (ack_s[k]) nack++; end
  endtask

  initial begin
    logic [15:0] rd;
    logic        e, b;
    int          lat, nack;
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 16'h0; wdata_s[k] = 16'h0;
    end
    repeat (3) @(negedge clock);
    chk("rst_ack", ack_s[0], 0);
    chk("rst_busy", busy_s[0], 0);
    chk("rst_rdata", rdata_s[0], 0);
    reset = 1'b0;
    @(negedge clock);

    xact(0, 1'b1, 16'h0004, 16'h0007, 0, rd, e, lat, nack, b);
    chk("st4_latency", lat, 3);
    chk("st4_err", e, 0);
    xact(0, 1'b0, 16'h0004, 16'h0, 0, rd, e, lat, nack, b);
    chk("ld4_rdata", rd, 16'h0007);
    chk("ld4_latency", lat, 3);

    xact(0, 1'b1, 16'h0008, 16'hBEEF, 0, rd, e, lat, nack, b);
    xact(0, 1'b0, 16'h000B, 16'h0, 0, rd, e, lat, nack, b);
    chk("ld_b_offset", rd, 16'hBEEF);

    xact(0, 1'b0, 16'h0004, 16'h0, 10, rd, e, lat, nack, b);
    chk("held_req_acks", nack, 1);
    chk("held_req_rdata", rd, 16'h0007);
    xact(0, 1'b0, 16'h0008, 16'h0, 0, rd, e, lat, nack, b);
    chk("second_acks", nack, 1);
    chk("second_rdata", rd, 16'hBEEF);

    xact(0, 1'b1, 16'h0000, 16'h1111, 0, rd, e, lat, nack, b);
    xact(0, 1'b1, 16'h1000, 16'h1234, 0, rd, e, lat, nack, b);
    chk("oob_st_err", e, 1);
    xact(0, 1'b0, 16'h0000, 16'h0, 0, rd, e, lat, nack, b);
    chk("no_alias_rdata", rd, 16'h1111);
    chk("no_alias_err", e, 0);
    xact(0, 1'b0, 16'hFFFC, 16'h0, 0, rd, e, lat, nack, b);
    chk("oob_ld_err", e, 1);
    chk("oob_ld_rdata", rd, 16'h0000);

    // Abort a store in WAIT with reset.
    xact(0, 1'b1, 16'h0008, 16'h0005, 0, rd, e, lat, nack, b);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 16'h0008; wdata_s[0] = 16'h0099;
    @(negedge clock);
    chk("abort_busy_pre", busy_s[0], 1);
    #1 reset = 1'b1; req_s[0] = 1'b0;
    #1 chk("abort_busy_now", busy_s[0], 0);
    chk("abort_ack_now", ack_s[0], 0);
    @(negedge clock);
    #1 reset = 1'b0;
    nack = 0;
    repeat (5) begin @(negedge clock); if (ack_s[0]) nack++; end
    chk("abort_no_ack", nack, 0);
    xact(0, 1'b0, 16'h0008, 16'h0, 0, rd, e, lat, nack, b);
    chk("abort_word2", rd, 16'h0005);
    xact(0, 1'b0, 16'h0004, 16'h0, 0, rd, e, lat, nack, b);
    chk("abort_word1", rd, 16'h0007);
    xact(0, 1'b0, 16'h0000, 16'h0, 0, rd, e, lat, nack, b);
    chk("abort_word0", rd, 16'h1111);

    xact(1, 1'b1, 16'h0000, 16'h0005, 0, rd, e, lat, nack, b);
    chk("w0_st_latency", lat, 1);
    xact(1, 1'b0, 16'h0000, 16'h0, 0, rd, e, lat, nack, b);
    chk("w0_ld_latency", lat, 1);
    chk("w0_ld_rdata", rd, 16'h0005);
    chk("w0_ld_busy", b, 1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
